// File: rtl/div_pkg.sv
// Shared definitions for the fractional and integer dividers:
// FSM state encoding and default operand/fraction widths.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W = 16;
    localparam int DEF_F = 10;

endpackage

// File: rtl/div_frac_seq_if.sv
// Request/result bundle of the sequential fraction divider, plus a debug view
// of the controller state.
interface div_frac_seq_if #(
    parameter int W = div_pkg::DEF_W,
    parameter int F = div_pkg::DEF_F
);
    import div_pkg::*;

    // Handshake: start is taken only while idle (busy=0, done=0); the result
    // fields are valid from the single-cycle done pulse until the next done.
    logic         start;
    logic         rnd;
    logic [W-1:0] rem_in;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [F-1:0] fraction;
    logic         inexact;
    logic         dbz;
    logic         ovf;
    state_t       state;

    modport master (
        output start, rnd, rem_in, divisor,
        input  busy, done, fraction, inexact, dbz, ovf, state
    );

    modport slave (
        input  start, rnd, rem_in, divisor,
        output busy, done, fraction, inexact, dbz, ovf, state
    );

endinterface

// File: rtl/div_frac_step.sv
// One restoring division step: double the partial remainder, subtract the
// divisor when it fits, and report the resulting quotient bit.
module div_frac_step #(
    parameter int W = div_pkg::DEF_W
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0] p;
    logic [W:0] diff;

    // rem < divisor always holds, so both candidates fit back into W bits.
    assign p        = {rem, 1'b0};
    assign diff     = p - {1'b0, divisor};
    assign q_bit    = (p >= {1'b0, divisor});
    assign rem_next = q_bit ? diff[W-1:0] : p[W-1:0];

endmodule

// File: rtl/div_frac_seq.sv
// Sequential restoring divider producing the F-bit binary fraction of
// rem_in/divisor, with optional round-half-up via one extra guard step.
module div_frac_seq
    import div_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int F = DEF_F
) (
    input  logic              clk,
    input  logic              res,
    div_frac_seq_if.slave     bus
);

    localparam int CW = $clog2(F + 2);

    state_t        state_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  div_q;
    logic [F:0]    q_q;
    logic          rnd_q;
    logic          dbz_err_q;
    logic          ovf_err_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] steps_q;
    logic          busy_q;
    logic          done_q;
    logic [F-1:0]  fraction_q;
    logic          inexact_q;
    logic          dbz_q;
    logic          ovf_q;

    logic [W-1:0]  rem_next;
    logic          q_bit;
    logic [F:0]    rounded;
    logic [F-1:0]  frac_rnd;
    logic          in_dbz;
    logic          in_ovf;

    div_frac_step #(.W(W)) u_step (
        .rem      (rem_q),
        .divisor  (div_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign in_dbz = (bus.divisor == '0);
    assign in_ovf = !in_dbz && (bus.rem_in >= bus.divisor);

    // Guard bit rounds the upper F bits; a carry out means the value hit 1.0.
    assign rounded  = {1'b0, q_q[F:1]} + {{F{1'b0}}, q_q[0]};
    assign frac_rnd = rounded[F] ? '1 : rounded[F-1:0];

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            div_q      <= '0;
            q_q        <= '0;
            rnd_q      <= 1'b0;
            dbz_err_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
            cnt_q      <= '0;
            steps_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fraction_q <= '0;
            inexact_q  <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        rem_q     <= bus.rem_in;
                        div_q     <= bus.divisor;
                        rnd_q     <= bus.rnd;
                        dbz_err_q <= in_dbz;
                        ovf_err_q <= in_ovf;
                        q_q       <= '0;
                        cnt_q     <= '0;
                        // Error cases finish after a single cycle with no steps.
                        if (in_dbz || in_ovf) steps_q <= '0;
                        else if (bus.rnd)     steps_q <= CW'(F + 1);
                        else                  steps_q <= CW'(F);
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == steps_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                        dbz_q   <= dbz_err_q;
                        ovf_q   <= ovf_err_q;
                        if (dbz_err_q || ovf_err_q) begin
                            fraction_q <= '1;
                            inexact_q  <= 1'b0;
                        end else if (rnd_q) begin
                            fraction_q <= frac_rnd;
                            inexact_q  <= q_q[0] | (rem_q != '0);
                        end else begin
                            fraction_q <= q_q[F-1:0];
                            inexact_q  <= (rem_q != '0);
                        end
                    end else begin
                        rem_q <= rem_next;
                        q_q   <= {q_q[F-1:0], q_bit};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.fraction = fraction_q;
    assign bus.inexact  = inexact_q;
    assign bus.dbz      = dbz_q;
    assign bus.ovf      = ovf_q;
    assign bus.state    = state_q;

endmodule

// File: doc/div_frac_seq.md
DIV_FRAC_SEQ -- requirements
Module: div_frac_seq

Interface
REQ-001 Parameter W, 16, divisor/remainder width (>=2).
REQ-002 Parameter F, 10, fraction bits produced (1..31).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port res  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request; sampled only in IDLE.
REQ-006 Port rnd  input  1  mode, captured with start: 0 = truncate, 1 = round-half-up.
REQ-007 Port rem_in  input  W  integer-division remainder (dividend numerator), captured with start.
REQ-008 Port divisor  input  W  divisor, captured with start.
REQ-009 Port busy  output  1  high while a request is in progress.
REQ-010 Port done  output  1  one-cycle pulse; result outputs valid.
REQ-011 Port fraction  output  F  binary fraction of rem_in/divisor, MSB = 2^-1.
REQ-012 Port inexact  output  1  nonzero final partial remainder (sticky).
REQ-013 Port dbz  output  1  divisor was zero.
REQ-014 Port ovf  output  1  rem_in >= divisor (nonzero divisor).

Function
REQ-015 FSM states: IDLE, CALC, DONE; reset state IDLE.
REQ-016 IDLE, start=1 at edge t: capture rem_in, divisor, rnd; busy=1 from t; zero-bit counter; go to CALC, except the error cases in REQ-021/REQ-022.
REQ-017 CALC: one restoring step per edge: p = 2*rem (W+1 bits); if p >= divisor then rem = p - divisor, shift in 1; else rem = p, shift in 0.
REQ-018 CALC lasts F steps (rnd=0) or F+1 steps (rnd=1, extra guard bit); then DONE.
REQ-019 Result registered on entering DONE: done=1 and busy=0 at edge t+F+1 (rnd=0) or t+F+2 (rnd=1); done is high exactly one cycle; FSM returns to IDLE.
REQ-020 rnd=1: fraction = upper F bits + guard bit; on carry-out, saturate to all ones. inexact = guard bit OR nonzero final remainder.
REQ-021 divisor=0: no iteration; done at t+1; dbz=1, ovf=0, fraction=all ones, inexact=0.
REQ-022 divisor!=0 and rem_in>=divisor: no iteration; done at t+1; ovf=1, dbz=0, fraction=all ones, inexact=0.
REQ-023 start while busy or in DONE is ignored; no queueing.
REQ-024 fraction, inexact, dbz, ovf hold their value from done until the next done; each done overwrites all four.
REQ-025 start may be asserted in the cycle after done (IDLE); back-to-back throughput = latency + 1 cycle.
REQ-026 Input ports are not required stable after the capture edge.

Reset
REQ-027 res=1 at an edge: state IDLE; busy, done, dbz, ovf, inexact = 0; fraction = 0; internal regs = 0.
REQ-028 res during CALC/DONE aborts with no done pulse; res has priority over start.

Structure
REQ-029 Shared package div_pkg holds the FSM state enum and default W/F constants; the integer divider reuses it.
REQ-030 Single sub-module div_frac_step (combinational compare/subtract/shift, parametrised W); FSM and counter in div_frac_seq.
REQ-031 Counter width $clog2(F+2); no latches; one always_ff block for state.

Verification (W=16, F=10)
REQ-032 rem_in=1, divisor=3, rnd=0 -> done at t+11, fraction=0x155, inexact=1, dbz=ovf=0.
REQ-033 rem_in=2, divisor=3, rnd=1 -> done at t+12, fraction=0x2AB, inexact=1; rnd=0 -> 0x2AA.
REQ-034 rem_in=1, divisor=2, rnd=0 -> fraction=0x200, inexact=0; divisor=0 -> done at t+1, dbz=1, fraction=0x3FF.
REQ-035 rem_in=65534, divisor=65535, rnd=1 -> saturate fraction=0x3FF, inexact=1; rem_in=5, divisor=5 -> done at t+1, ovf=1.
REQ-036 res pulse at t+5 of a request -> no done, busy=0 next cycle, outputs 0; start at t+3 while busy -> ignored, single done.
REQ-037 Random self-check, 10k requests: fraction == floor(rem_in*2^F/divisor) (rnd=0), with back-to-back starts.
